uart_tx_buffered: RTL and testbench

Buffered UART transmitter: accepts bytes from an on-chip producer over a valid/ready handshake, holds them in a ring buffer, and serialises them onto `tx` as 8N1 frames. It is the transmit-side counterpart to the receive-and-buffer path. Firmware-side logic (string generators, command responders) can push whole messages in a burst without tracking UART bit timing.

---
 rtl/uart_tx_buffered.sv | 154 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a ring buffer fed over valid/ready, drained
// by a frame serialiser that chains queued bytes with no idle gap.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bits, LSB first, from the shift register
// STOP  | stop bit (1); pops the next byte straight into START if one is queued
`timescale 1ns/1ps

module uart_tx_buffered #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_SIZE  = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(BUFFER_SIZE):0]  level,
  output logic                          empty,
  output logic                          full
);

  localparam int PTR_W  = $clog2(BUFFER_SIZE);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(BUFFER_SIZE);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [BUFFER_SIZE];

  logic push;
  logic pop;
  logic bit_end;

  assign empty    = (count_q == '0);
  assign full     = (count_q == LVL_FULL);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign level    = count_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + BAUD_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line and busy are registered from the next state so they change on the
    // same edge as the state transition.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, BUFFER_SIZE=32;
// a negedge line decoder recovers bytes and start positions independently.
`timescale 1ns/1ps

module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int BSZ = 32;
  localparam int LW  = $clog2(BSZ) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          tx;
  logic          busy;
  logic [LW-1:0] level;
  logic          empty;
  logic          full;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .DATA_WIDTH(8),
    .BUFFER_SIZE(BSZ),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .busy(busy),
    .level(level),
    .empty(empty),
    .full(full)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // Line decoder: samples mid-bit on the falling edge.
  int         gcnt = 0;
  bit         dec_busy = 1'b0;
  int         dec_pos = 0;
  logic [7:0] dec_byte = 8'h00;
  logic [7:0] bytes_q[$];
  int         starts_q[$];
  int         frame_err = 0;
  int         busy_cnt = 0;

  always @(negedge clk) begin
    gcnt++;
    if (busy === 1'b1) busy_cnt++;
    if (rst) begin
      dec_busy = 1'b0;
    end else if (!dec_busy) begin
      if (tx === 1'b0) begin
        dec_busy = 1'b1;
        dec_pos  = 0;
        starts_q.push_back(gcnt);
      end
    end else begin
      dec_pos++;
      for (int j = 0; j < 8; j++)
        if (dec_pos == CPB * (j + 1) + CPB / 2) dec_byte[j] = tx;
      if (dec_pos == 9 * CPB + CPB / 2) begin
        if (tx !== 1'b1) frame_err++;
        bytes_q.push_back(dec_byte);
        dec_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    bit tmo;
    n = 0;
    while (!(empty === 1'b1 && busy === 1'b0) && n < bound) begin
      tick();
      n++;
    end
    tick();
    tmo = (n >= bound);
    check(tag, 64'(tmo), 64'(0));
  endtask

  function automatic logic [39:0] frame_bits(input logic [7:0] byt);
    logic [39:0] v;
    for (int k = 0; k < 40; k++) begin
      int b;
      b = k / CPB;
      if (b == 0)      v[k] = 1'b0;
      else if (b == 9) v[k] = 1'b1;
      else             v[k] = byt[b-1];
    end
    return v;
  endfunction

  initial begin
    logic [39:0] obs_tx;
    logic [39:0] obs_busy;
    int b0, s0, bc0, fe0;
    int acc, cyc, run, max_run, rise_n, mism;
    int rise_t[2];
    bit rdy, prev_rdy, full_seen, idle_bad;

    // Reset
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("rst_in_ready_after", 64'(in_ready), 64'(1));
    check("rst_tx", 64'(tx), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));

    // Single byte 0x55
    b0 = bytes_q.size();
    in_valid = 1'b1;
    in_data  = 8'h55;
    tick();
    in_valid = 1'b0;
    check("single_level_after_push", 64'(level), 64'(1));
    check("single_tx_before_pop", 64'(tx), 64'(1));
    check("single_busy_before_pop", 64'(busy), 64'(0));
    tick();
    for (int k = 0; k < 40; k++) begin
      obs_tx[k]   = tx;
      obs_busy[k] = busy;
      tick();
    end
    check("single_line_bits", 64'(obs_tx), 64'(frame_bits(8'h55)));
    check("single_busy_40", 64'(obs_busy), 64'(40'hFF_FFFF_FFFF));
    check("single_busy_end", 64'(busy), 64'(0));
    check("single_tx_end", 64'(tx), 64'(1));
    check("single_level_end", 64'(level), 64'(0));
    check("single_decoded", 64'(bytes_q.size() - b0), 64'(1));
    check("single_decoded_val", 64'(bytes_q[b0]), 64'(8'h55));

    // Back-to-back A3, 00, FF
    b0  = bytes_q.size();
    s0  = starts_q.size();
    bc0 = busy_cnt;
    fe0 = frame_err;
    in_valid = 1'b1;
    in_data = 8'hA3; tick();
    in_data = 8'h00; tick();
    in_data = 8'hFF; tick();
    in_valid = 1'b0;
    wait_idle("b2b_timeout", 400);
    check("b2b_count", 64'(bytes_q.size() - b0), 64'(3));
    check("b2b_byte0", 64'(bytes_q[b0]), 64'(8'hA3));
    check("b2b_byte1", 64'(bytes_q[b0+1]), 64'(8'h00));
    check("b2b_byte2", 64'(bytes_q[b0+2]), 64'(8'hFF));
    check("b2b_gap01", 64'(starts_q[s0+1] - starts_q[s0]), 64'(40));
    check("b2b_gap12", 64'(starts_q[s0+2] - starts_q[s0+1]), 64'(40));
    check("b2b_busy_cycles", 64'(busy_cnt - bc0), 64'(120));
    check("b2b_framing", 64'(frame_err - fe0), 64'(0));

    // Full / backpressure and wrap-around: 100 bytes from reset release
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    #1;
    b0 = bytes_q.size();
    fe0 = frame_err;
    acc = 0; cyc = 0; run = 0; max_run = 0; rise_n = 0;
    prev_rdy = 1'b1; full_seen = 1'b0;
    while (acc < 100 && cyc < 6000) begin
      rdy = in_ready;
      if (!rdy && !full_seen) begin
        full_seen = 1'b1;
        check("full_accepted", 64'(acc), 64'(33));
        check("full_flag", 64'(full), 64'(1));
        check("full_level", 64'(level), 64'(BSZ));
      end
      if (full_seen) begin
        if (rdy) run++;
        else begin
          if (run > max_run) max_run = run;
          run = 0;
        end
        if (rdy && !prev_rdy) begin
          if (rise_n < 2) rise_t[rise_n] = cyc;
          rise_n++;
        end
      end
      if (rdy) acc++;
      prev_rdy = rdy;
      tick();
      cyc++;
      if (rdy && full_seen && rise_n <= 2) begin
        check("refill_level", 64'(level), 64'(BSZ));
        check("refill_ready", 64'(in_ready), 64'(0));
      end
      in_data = 8'(acc);
      if (acc == 100) in_valid = 1'b0;
    end
    check("wrap_all_accepted", 64'(acc), 64'(100));
    check("bp_one_push_per_pop", 64'(max_run), 64'(1));
    check("bp_pop_interval", 64'(rise_t[1] - rise_t[0]), 64'(40));
    wait_idle("wrap_timeout", 6000);
    check("wrap_count", 64'(bytes_q.size() - b0), 64'(100));
    mism = 0;
    for (int i = 0; i < 100; i++)
      if (b0 + i >= bytes_q.size() || bytes_q[b0+i] !== 8'(i)) mism++;
    check("wrap_order", 64'(mism), 64'(0));
    check("wrap_framing", 64'(frame_err - fe0), 64'(0));

    // Reset mid-frame during data bit 3 with 5 bytes queued
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_data = 8'h44; tick();
    in_data = 8'h55; tick();
    in_valid = 1'b0;
    check("midrst_level_queued", 64'(level), 64'(4));
    for (int i = 0; i < 14; i++) tick();
    check("midrst_busy_before", 64'(busy), 64'(1));
    b0 = bytes_q.size();
    rst = 1'b1;
    #1;
    check("midrst_in_ready_low", 64'(in_ready), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("midrst_tx", 64'(tx), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_level", 64'(level), 64'(0));
    check("midrst_empty", 64'(empty), 64'(1));
    check("midrst_full", 64'(full), 64'(0));
    check("midrst_in_ready_high", 64'(in_ready), 64'(1));
    idle_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) idle_bad = 1'b1;
      tick();
    end
    check("midrst_line_idle", 64'(idle_bad), 64'(0));
    check("midrst_no_bytes", 64'(bytes_q.size() - b0), 64'(0));
    fe0 = frame_err;
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    wait_idle("midrst_timeout", 200);
    check("midrst_count", 64'(bytes_q.size() - b0), 64'(1));
    check("midrst_byte", 64'(bytes_q[b0]), 64'(8'h3C));
    check("midrst_framing", 64'(frame_err - fe0), 64'(0));

    // Simultaneous push/pop on the final stop-bit cycle
    b0 = bytes_q.size();
    s0 = starts_q.size();
    in_valid = 1'b1;
    in_data = 8'h5A; tick();
    in_data = 8'hC3; tick();
    in_valid = 1'b0;
    check("simul_level_start", 64'(level), 64'(1));
    check("simul_busy_start", 64'(busy), 64'(1));
    for (int i = 0; i < 39; i++) tick();
    check("simul_stop_tx", 64'(tx), 64'(1));
    check("simul_stop_level", 64'(level), 64'(1));
    in_valid = 1'b1;
    in_data = 8'h96;
    tick();
    in_valid = 1'b0;
    check("simul_level_kept", 64'(level), 64'(1));
    check("simul_start_tx", 64'(tx), 64'(0));
    check("simul_start_busy", 64'(busy), 64'(1));
    wait_idle("simul_timeout", 400);
    check("simul_count", 64'(bytes_q.size() - b0), 64'(3));
    check("simul_byte0", 64'(bytes_q[b0]), 64'(8'h5A));
    check("simul_byte1", 64'(bytes_q[b0+1]), 64'(8'hC3));
    check("simul_byte2", 64'(bytes_q[b0+2]), 64'(8'h96));
    check("simul_gap12", 64'(starts_q[s0+2] - starts_q[s0+1]), 64'(40));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
